// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared ALU.
// Handles one transaction at a time through IDLE -> ISSUE -> CAPTURE.
// The operands and opcode are registered toward the ALU. The result and the
// done pulse are registered back to the requester that won the grant.
// Optional build macro: ALU_ARB_STATS_EN adds saturating 8-bit grant counters
// (grant_cnt0/grant_cnt1).

// Per-requester return path: result register, done pulse, optional counter.
module alu_arbiter_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]       grant_cnt
`endif
);

    // Capture the ALU result and raise done for the single cycle that follows CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= cap;
            if (cap) result <= alu_result;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Count completions for this requester. The count saturates so it cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          grant_cnt <= 8'd0;
        else if (cap && grant_cnt != 8'hff) grant_cnt <= grant_cnt + 8'd1;
    end
`endif

endmodule

module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1
`endif
);

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t                            state;
    logic                              gnt;   // requester owning the in-flight op
    logic                              ptr;   // preferred requester when both ask
    logic                              sel;
    logic [NUM_REQ-1:0][2:0]           op;
    logic [NUM_REQ-1:0][WIDTH-1:0]     a, b, res;
    logic [NUM_REQ-1:0]                cap, done;
`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][7:0]           cnt;
`endif

    assign op = {op1, op0};
    assign a  = {A1, A0};
    assign b  = {B1, B0};

    // Pick the winner. A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        sel = req1;
        if (req0 && req1) sel = ptr;
    end

    // Transaction FSM. The ALU-facing registers hold their values outside a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            ptr    <= 1'b0;
            busy   <= 1'b0;
            alu_op <= '0;
            alu_A  <= '0;
            alu_B  <= '0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    gnt    <= sel;
                    alu_op <= op[sel];
                    alu_A  <= a[sel];
                    alu_B  <= b[sel];
                    busy   <= 1'b1;
                    state  <= ISSUE;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    ptr   <= ~gnt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign cap[i] = (state == CAPTURE) && (gnt == 1'(i));
        alu_arbiter_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .cap        (cap[i]),
            .alu_result (alu_result),
            .done       (done[i]),
            .result     (res[i])
`ifdef ALU_ARB_STATS_EN
            ,
            .grant_cnt  (cnt[i])
`endif
        );
    end

    assign done0   = done[0];
    assign done1   = done[1];
    assign result0 = res[0];
    assign result1 = res[1];
`ifdef ALU_ARB_STATS_EN
    assign grant_cnt0 = cnt[0];
    assign grant_cnt1 = cnt[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table plus hand-written sequences for alu_arbiter.
// The shared ALU is modelled as alu_result = ~(alu_A | alu_B).
module tb_alu_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [2:0]       op0 = '0, op1 = '0;
    logic [WIDTH-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_A, alu_B, alu_result;
    logic             done0, done1, busy;
    logic [WIDTH-1:0] result0, result1;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]       grant_cnt0, grant_cnt1;
`endif

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .A0         (A0),
        .B0         (B0),
        .A1         (A1),
        .B1         (B1),
        .alu_op     (alu_op),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_result (alu_result),
        .done0      (done0),
        .done1      (done1),
        .result0    (result0),
        .result1    (result1),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;
    assign alu_result = ~(alu_A | alu_B);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // The two done pulses must never overlap.
    always @(negedge clk) begin
        if (!rst && done0 && done1) check("done_exclusive", 32'd1, 32'd0);
    end

    typedef struct {
        logic             r0, r1;
        logic [2:0]       op0, op1;
        logic [WIDTH-1:0] a0, b0, a1, b1;
        logic             g;      // expected grant
        logic [WIDTH-1:0] res;    // expected ~(A|B) of the granted requester
    } vec_t;

    vec_t             vt[6];
    logic [WIDTH-1:0] exp_r0, exp_r1;
    int               cyc;
    int               dt[$];
    logic             did[$];
    logic [WIDTH-1:0] dres[$];
    logic             seen;

    initial begin
        // The pointer starts at 0 and moves to the other side after every completion.
        vt[0] = '{1, 0, 3'd3, 3'd0, 4'b1001, 4'b1010, 4'b0000, 4'b0000, 0, 4'b0100};
        vt[1] = '{0, 1, 3'd0, 3'd5, 4'b0000, 4'b0000, 4'b0011, 4'b0100, 1, 4'b1000};
        vt[2] = '{1, 1, 3'd1, 3'd6, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 4'b1111};
        vt[3] = '{1, 1, 3'd2, 3'd7, 4'b0101, 4'b0000, 4'b0001, 4'b0001, 1, 4'b1110};
        vt[4] = '{0, 1, 3'd0, 3'd4, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 4'b0111};
        vt[5] = '{1, 1, 3'd7, 3'd2, 4'b1100, 4'b0011, 4'b0110, 4'b0000, 0, 4'b0000};

        // Reset state
        #1;
        check("rst_busy", busy, 0);
        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_A", alu_A, 0);
        check("rst_alu_B", alu_B, 0);
        check("rst_result0", result0, 0);
        check("rst_result1", result1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single transactions
        exp_r0 = '0;
        exp_r1 = '0;
        for (int i = 0; i < 6; i++) begin
            req0 = vt[i].r0; req1 = vt[i].r1;
            op0 = vt[i].op0; op1 = vt[i].op1;
            A0 = vt[i].a0; B0 = vt[i].b0; A1 = vt[i].a1; B1 = vt[i].b1;
            @(negedge clk);
            check($sformatf("v%0d_busy", i), busy, 1);
            cyc = 1;
            while (cyc < 8 && !(done0 || done1)) begin
                @(negedge clk);
                cyc++;
            end
            req0 = 1'b0; req1 = 1'b0;
            if (vt[i].g) exp_r1 = vt[i].res; else exp_r0 = vt[i].res;
            check($sformatf("v%0d_latency", i), cyc, 3);
            check($sformatf("v%0d_done0", i), done0, !vt[i].g);
            check($sformatf("v%0d_done1", i), done1, vt[i].g);
            check($sformatf("v%0d_result0", i), result0, exp_r0);
            check($sformatf("v%0d_result1", i), result1, exp_r1);
            check($sformatf("v%0d_alu_op", i), alu_op, vt[i].g ? vt[i].op1 : vt[i].op0);
            check($sformatf("v%0d_alu_A", i), alu_A, vt[i].g ? vt[i].a1 : vt[i].a0);
            check($sformatf("v%0d_alu_B", i), alu_B, vt[i].g ? vt[i].b1 : vt[i].b0);
            @(negedge clk);
            check($sformatf("v%0d_done_gone", i), done0 | done1, 0);
            check($sformatf("v%0d_idle", i), busy, 0);
        end

        // Both requesters held from reset release: pointer at 0, then alternate
        rst = 1'b1;
        #1;
        check("rst2_result1", result1, 0);
        req0 = 1'b1; req1 = 1'b1;
        A0 = 4'b0000; B0 = 4'b1111; A1 = 4'b0001; B1 = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                dt.push_back(c);
                did.push_back(done1);
                dres.push_back(done1 ? result1 : result0);
            end
            if (c == 12) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        check("rr_count", dt.size(), 4);
        if (dt.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rr_time%0d", k), dt[k], 3 * (k + 1));
                check($sformatf("rr_grant%0d", k), did[k], k % 2);
                check($sformatf("rr_result%0d", k), dres[k], (k % 2) ? 4'b1100 : 4'b0000);
            end
        end

        // Asynchronous reset in ISSUE aborts the transaction
        req0 = 1'b1; op0 = 3'd5; A0 = 4'b1001; B0 = 4'b1010;
        @(negedge clk);
        check("abort_busy", busy, 1);
        check("abort_alu_A", alu_A, 4'b1001);
        #2 rst = 1'b1;
        #1;
        check("abort_busy0", busy, 0);
        check("abort_alu_op0", alu_op, 0);
        check("abort_alu_A0", alu_A, 0);
        check("abort_alu_B0", alu_B, 0);
        check("abort_result0", result0, 0);
        check("abort_result1", result1, 0);
        check("abort_done", done0 | done1, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done0 || done1 || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);

`ifdef ALU_ARB_STATS_EN
        // 260 requester-0 completions saturate the counter at 255
        check("cnt0_reset", grant_cnt0, 0);
        for (int t = 0; t < 260; t++) begin
            req0 = 1'b1;
            cyc = 0;
            while (cyc < 8 && !done0) begin
                @(negedge clk);
                cyc++;
            end
            req0 = 1'b0;
            if (cyc >= 8) check("cnt_txn_timeout", cyc, 3);
            @(negedge clk);
        end
        check("cnt0_sat", grant_cnt0, 255);
        check("cnt1_zero", grant_cnt1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
